// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detection: load-use, branch operand hazards in ID, and
// multi-cycle mult/div occupancy, producing stall, bubble and flush controls.
module hazard_stall_unit #(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  RSReg_ID,
  input  logic [4:0]  RTReg_ID,
  input  logic [4:0]  RTReg_EX,
  input  logic        MemRead_EX,
  input  logic [4:0]  RDReg_EX,
  input  logic        EX_RegWrite,
  input  logic [4:0]  RDReg_M,
  input  logic        MemRead_M,
  input  logic        Branch_ID,
  input  logic        BranchTaken_ID,
  input  logic        Jump_ID,
  input  logic        MulDivStart_ID,
  input  logic        MulDivUse_ID,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic        MulDivBusy,
  output logic [15:0] StallCycles
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t          state;
  md_state_t          next_state;
  logic [CNT_W-1:0]   md_cnt;
  logic [CNT_W-1:0]   md_cnt_next;

  logic load_use;
  logic branch_alu;
  logic branch_load;
  logic md_hazard;
  logic stall;

  // Hazard terms; register 0 is hardwired and never creates a dependency.
  // While reset is asserted the unit behaves as if idle in RUN.
  always_comb begin
    load_use    = MemRead_EX && (RTReg_EX != '0) &&
                  ((RTReg_EX == RSReg_ID) || (RTReg_EX == RTReg_ID));
    branch_alu  = Branch_ID && EX_RegWrite && (RDReg_EX != '0) &&
                  ((RDReg_EX == RSReg_ID) || (RDReg_EX == RTReg_ID));
    branch_load = Branch_ID && MemRead_M && (RDReg_M != '0) &&
                  ((RDReg_M == RSReg_ID) || (RDReg_M == RTReg_ID));
    md_hazard   = (state == MD_BUSY) && !Rst && (MulDivUse_ID || MulDivStart_ID);
    stall       = load_use || branch_alu || branch_load || md_hazard;
  end

  // Pipeline control outputs; a stalled branch/jump flushes only once it proceeds.
  always_comb begin
    PCWrite    = !stall;
    IFIDWrite  = !stall;
    IDEXBubble = stall;
    IFIDFlush  = (BranchTaken_ID || Jump_ID) && !stall;
  end

  // Mult/div occupancy FSM next-state logic.
  always_comb begin
    next_state  = state;
    md_cnt_next = md_cnt;
    case (state)
      RUN: begin
        if (MulDivStart_ID && !stall) begin
          next_state  = MD_BUSY;
          md_cnt_next = CNT_W'(MULDIV_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (md_cnt <= CNT_W'(1)) begin
          next_state  = RUN;
          md_cnt_next = '0;
        end else begin
          md_cnt_next = md_cnt - CNT_W'(1);
        end
      end
      default: begin
        next_state  = RUN;
        md_cnt_next = '0;
      end
    endcase
  end

  // State, busy flag and saturating stall counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= RUN;
      md_cnt      <= '0;
      MulDivBusy  <= 1'b0;
      StallCycles <= '0;
    end else begin
      state      <= next_state;
      md_cnt     <= md_cnt_next;
      MulDivBusy <= (next_state == MD_BUSY);
      if (stall && (StallCycles != '1)) begin
        StallCycles <= StallCycles + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a vector table for single-cycle
// hazard decoding plus hand-written mult/div, reset and saturation sequences.
module tb_hazard_stall_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  RSReg_ID, RTReg_ID, RTReg_EX, RDReg_EX, RDReg_M;
  logic        MemRead_EX, EX_RegWrite, MemRead_M;
  logic        Branch_ID, BranchTaken_ID, Jump_ID, MulDivStart_ID, MulDivUse_ID;
  logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivBusy;
  logic [15:0] StallCycles;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = 16'd0;

  hazard_stall_unit #(.MULDIV_LAT(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .RSReg_ID(RSReg_ID), .RTReg_ID(RTReg_ID), .RTReg_EX(RTReg_EX),
    .MemRead_EX(MemRead_EX), .RDReg_EX(RDReg_EX), .EX_RegWrite(EX_RegWrite),
    .RDReg_M(RDReg_M), .MemRead_M(MemRead_M), .Branch_ID(Branch_ID),
    .BranchTaken_ID(BranchTaken_ID), .Jump_ID(Jump_ID),
    .MulDivStart_ID(MulDivStart_ID), .MulDivUse_ID(MulDivUse_ID),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
    .IFIDFlush(IFIDFlush), .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, rt_ex;
    logic       mr_ex;
    logic [4:0] rd_ex;
    logic       rw_ex;
    logic [4:0] rd_m;
    logic       mr_m, br, tk, jp;
    logic       stall, flush;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rt_ex, logic mr_ex, logic [4:0] rd_ex,
                              logic rw_ex, logic [4:0] rd_m, logic mr_m,
                              logic br, logic tk, logic jp, logic stall, logic flush);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.rt_ex = rt_ex; v.mr_ex = mr_ex;
    v.rd_ex = rd_ex; v.rw_ex = rw_ex; v.rd_m = rd_m; v.mr_m = mr_m;
    v.br = br; v.tk = tk; v.jp = jp; v.stall = stall; v.flush = flush;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    RSReg_ID = 5'd0; RTReg_ID = 5'd0; RTReg_EX = 5'd0; RDReg_EX = 5'd0; RDReg_M = 5'd0;
    MemRead_EX = 1'b0; EX_RegWrite = 1'b0; MemRead_M = 1'b0;
    Branch_ID = 1'b0; BranchTaken_ID = 1'b0; Jump_ID = 1'b0;
    MulDivStart_ID = 1'b0; MulDivUse_ID = 1'b0;
  endtask

  // Check the combinational controls against an expected stall/flush.
  task automatic chk_ctrl(string name, logic stall, logic flush);
    chk({name, ".PCWrite"},    {15'd0, PCWrite},    {15'd0, !stall});
    chk({name, ".IFIDWrite"},  {15'd0, IFIDWrite},  {15'd0, !stall});
    chk({name, ".IDEXBubble"}, {15'd0, IDEXBubble}, {15'd0, stall});
    chk({name, ".IFIDFlush"},  {15'd0, IFIDFlush},  {15'd0, flush});
  endtask

  // Advance one edge, updating the stall-count model, then settle.
  task automatic tick(logic stall);
    @(posedge Clk);
    if (Rst) exp_cnt = 16'd0;
    else if (stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  initial begin
    vecs[0]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk("lu_rs",       8, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk("lu_rt",       1, 9, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[3]  = mk("lu_zero",     0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk("lu_noload",   8, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk("br_alu",      3, 4, 0, 0, 3, 1, 0, 0, 1, 1, 0, 1, 0);
    vecs[6]  = mk("alu_nobr",    3, 4, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk("br_alu_zero", 0, 4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    vecs[8]  = mk("br_load",     1, 5, 0, 0, 0, 0, 5, 1, 1, 1, 0, 1, 0);
    vecs[9]  = mk("br_taken",    1, 2, 0, 0, 7, 1, 6, 1, 1, 1, 0, 0, 1);
    vecs[10] = mk("jump",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[11] = mk("jump_lu",     8, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[12] = mk("lu_and_bralu",6, 2, 6, 1, 2, 1, 0, 0, 1, 0, 0, 1, 0);
    vecs[13] = mk("br_nowrite",  3, 4, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 1);
    vecs[14] = mk("br_m_noload", 5, 4, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0);

    // Reset: registered state cleared, controls as if idle in RUN.
    idle_inputs();
    Rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("rst.StallCycles", StallCycles, 16'd0);
    chk("rst.MulDivBusy", {15'd0, MulDivBusy}, 16'd0);
    chk_ctrl("rst", 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;

    // Single-cycle hazard table.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge Clk);
      idle_inputs();
      RSReg_ID = vecs[i].rs; RTReg_ID = vecs[i].rt; RTReg_EX = vecs[i].rt_ex;
      MemRead_EX = vecs[i].mr_ex; RDReg_EX = vecs[i].rd_ex; EX_RegWrite = vecs[i].rw_ex;
      RDReg_M = vecs[i].rd_m; MemRead_M = vecs[i].mr_m; Branch_ID = vecs[i].br;
      BranchTaken_ID = vecs[i].tk; Jump_ID = vecs[i].jp;
      #1;
      chk_ctrl(vecs[i].name, vecs[i].stall, vecs[i].flush);
      tick(vecs[i].stall);
      chk({vecs[i].name, ".StallCycles"}, StallCycles, exp_cnt);
    end

    // Stalled taken branch flushes only in its proceeding cycle.
    @(negedge Clk);
    idle_inputs();
    Branch_ID = 1'b1; BranchTaken_ID = 1'b1; MemRead_M = 1'b1; RDReg_M = 5'd5; RTReg_ID = 5'd5;
    #1;
    chk_ctrl("brseq.c0", 1'b1, 1'b0);
    tick(1'b1);
    @(negedge Clk);
    MemRead_M = 1'b0; RDReg_M = 5'd0;
    #1;
    chk_ctrl("brseq.c1", 1'b0, 1'b1);
    tick(1'b0);
    chk("brseq.StallCycles", StallCycles, exp_cnt);

    // Mult/div start then mfhi/mflo held: 3 busy/stall cycles, released on the 4th.
    @(negedge Clk);
    idle_inputs();
    MulDivStart_ID = 1'b1;
    #1;
    chk_ctrl("md.start", 1'b0, 1'b0);
    tick(1'b0);
    @(negedge Clk);
    MulDivStart_ID = 1'b0; MulDivUse_ID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("md.busy%0d", c), {15'd0, MulDivBusy}, 16'd1);
      chk_ctrl($sformatf("md.stall%0d", c), 1'b1, 1'b0);
      tick(1'b1);
      @(negedge Clk);
    end
    #1;
    chk("md.busy_end", {15'd0, MulDivBusy}, 16'd0);
    chk_ctrl("md.release", 1'b0, 1'b0);
    chk("md.StallCycles", StallCycles, exp_cnt);
    tick(1'b0);

    // Back-to-back start: stalls while busy, accepted on first RUN cycle.
    @(negedge Clk);
    idle_inputs();
    MulDivStart_ID = 1'b1;
    tick(1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_ctrl($sformatf("md2.stall%0d", c), 1'b1, 1'b0);
      tick(1'b1);
    end
    #1;
    chk_ctrl("md2.accept", 1'b0, 1'b0);
    tick(1'b0);
    chk("md2.busy_again", {15'd0, MulDivBusy}, 16'd1);
    @(negedge Clk);
    MulDivStart_ID = 1'b0;
    for (int c = 0; c < 3; c++) tick(1'b0);
    chk("md2.busy_done", {15'd0, MulDivBusy}, 16'd0);

    // Reset in the 2nd busy cycle abandons the countdown.
    @(negedge Clk);
    MulDivStart_ID = 1'b1;
    tick(1'b0);
    @(negedge Clk);
    MulDivStart_ID = 1'b0; MulDivUse_ID = 1'b1;
    tick(1'b1);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("rstmd.busy_before", {15'd0, MulDivBusy}, 16'd1);
    chk_ctrl("rstmd.in_reset", 1'b0, 1'b0);
    tick(1'b0);
    chk("rstmd.MulDivBusy", {15'd0, MulDivBusy}, 16'd0);
    chk("rstmd.StallCycles", StallCycles, 16'd0);
    @(negedge Clk);
    Rst = 1'b0; MulDivUse_ID = 1'b0; MulDivStart_ID = 1'b1;
    #1;
    chk_ctrl("rstmd.restart", 1'b0, 1'b0);
    tick(1'b0);
    chk("rstmd.busy_restart", {15'd0, MulDivBusy}, 16'd1);
    @(negedge Clk);
    MulDivStart_ID = 1'b0;
    for (int c = 0; c < 3; c++) tick(1'b0);

    // Saturation under a long load-use stall.
    @(negedge Clk);
    idle_inputs();
    MemRead_EX = 1'b1; RTReg_EX = 5'd8; RSReg_ID = 5'd8;
    for (int c = 0; c < 65540; c++) begin
      tick(1'b1);
      if (c == 65533) chk("sat.FFFE", StallCycles, exp_cnt);
    end
    chk("sat.hold", StallCycles, 16'hFFFF);
    chk("sat.model", StallCycles, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter MULDIV_LAT, default 4, mult/div occupancy in cycles; legal range 2..15.
REQ-002 Clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 RSReg_ID, RTReg_ID  input  5 each  source register fields of the instruction in ID.
REQ-005 RTReg_EX  input  5  load destination of the instruction in EX.
REQ-006 MemRead_EX  input  1  EX instruction is a load.
REQ-007 RDReg_EX  input  5  ALU destination of the instruction in EX.
REQ-008 EX_RegWrite  input  1  EX instruction writes the register file.
REQ-009 RDReg_M  input  5  destination of the instruction in MEM.
REQ-010 MemRead_M  input  1  MEM instruction is a load.
REQ-011 Branch_ID  input  1  ID instruction is a branch compared in ID.
REQ-012 BranchTaken_ID  input  1  ID branch resolved taken.
REQ-013 Jump_ID  input  1  ID instruction is a jump.
REQ-014 MulDivStart_ID  input  1  ID instruction is mult/div.
REQ-015 MulDivUse_ID  input  1  ID instruction is mfhi/mflo.
REQ-016 PCWrite  output  1  PC update enable.
REQ-017 IFIDWrite  output  1  IF/ID register write enable.
REQ-018 IDEXBubble  output  1  zero ID/EX control fields this cycle.
REQ-019 IFIDFlush  output  1  clear IF/ID on next edge.
REQ-020 MulDivBusy  output  1  registered; high while in MD_BUSY.
REQ-021 StallCycles  output  16  registered saturating count of stall cycles.

Function
REQ-022 Hazard terms are combinational from current inputs and state; register 0 never matches.
REQ-023 Load-use: MemRead_EX, RTReg_EX!=0, RTReg_EX equals RSReg_ID or RTReg_ID; RTReg_ID compared unconditionally.
REQ-024 Branch-ALU: Branch_ID, EX_RegWrite, RDReg_EX!=0, RDReg_EX equals RSReg_ID or RTReg_ID.
REQ-025 Branch-load: Branch_ID, MemRead_M, RDReg_M!=0, RDReg_M equals RSReg_ID or RTReg_ID.
REQ-026 MulDiv: state MD_BUSY and (MulDivUse_ID or MulDivStart_ID).
REQ-027 Stall = OR of REQ-023..026; Stall forces PCWrite=0, IFIDWrite=0, IDEXBubble=1; else PCWrite=1, IFIDWrite=1, IDEXBubble=0.
REQ-028 IFIDFlush = (BranchTaken_ID or Jump_ID) and not Stall; a stalled branch flushes only in its non-stall cycle.
REQ-029 FSM states RUN, MD_BUSY; 4-bit down-counter MdCnt.
REQ-030 RUN -> MD_BUSY when MulDivStart_ID and not Stall; MdCnt loads MULDIV_LAT-1.
REQ-031 MD_BUSY: MdCnt decrements each cycle; at MdCnt=1 transitions to RUN on the same edge that makes MdCnt=0.
REQ-032 MulDivStart_ID in MD_BUSY stalls; accepted in the first RUN cycle after MD_BUSY exits.
REQ-033 Busy window: MulDivBusy high exactly MULDIV_LAT-1 cycles after an accepted start.
REQ-034 StallCycles increments by 1 on every edge where Stall=1; holds at 16'hFFFF, no wrap.
REQ-035 Simultaneous hazards produce a single stall; StallCycles increments by 1 only.

Reset
REQ-036 Rst=1 at an edge: state RUN, MdCnt=0, MulDivBusy=0, StallCycles=0, irrespective of current state.
REQ-037 During Rst cycles the combinational outputs follow REQ-027/028 with state treated as RUN.
REQ-038 Rst asserted mid-MD_BUSY abandons the countdown; a next MulDivStart_ID is accepted immediately.

Verification
REQ-039 Load-use: MemRead_EX=1, RTReg_EX=8, RSReg_ID=8 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1, StallCycles 0->1.
REQ-040 Zero register: MemRead_EX=1, RTReg_EX=0, RSReg_ID=0 -> no stall, PCWrite=1.
REQ-041 Branch-load: Branch_ID=1, BranchTaken_ID=1, MemRead_M=1, RDReg_M=5, RTReg_ID=5 -> stall, IFIDFlush=0; next cycle, no hazard -> IFIDFlush=1.
REQ-042 MulDiv, MULDIV_LAT=4: MulDivStart_ID pulse, then MulDivUse_ID held -> MulDivBusy high 3 cycles, stall 3 cycles, released on the 4th.
REQ-043 Rst pulse in the 2nd MD_BUSY cycle -> MulDivBusy=0 and StallCycles=0 after that edge.
REQ-044 Saturation: 65540 consecutive load-use cycles -> StallCycles holds 16'hFFFF.
